// File: rtl/online_ccm_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the online constant-coefficient multiplier.
// Digit encoding is {p,n} with value p-n; CSD recoding of the coefficient happens at elaboration.
package online_ccm_pipe_pkg;

  localparam int          DIG_P    = 1;
  localparam int          DIG_N    = 0;
  localparam logic [1:0]  DIG_ZERO = 2'b00;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Non-adjacent form: an odd remainder takes +1 when it is 1 mod 4, otherwise -1.
  function automatic int csd_digit(input int coef, input int i);
    int c;
    int d;
    c = coef;
    d = 0;
    for (int k = 0; k <= i; k++) begin
      if ((c % 2) != 0) begin
        d = 2 - (c % 4);
        c = (c - d) / 2;
      end else begin
        d = 0;
        c = c / 2;
      end
    end
    return d;
  endfunction

  function automatic int csd_nz_count(input int coef);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      if (csd_digit(coef, i) != 0) n++;
    return n;
  endfunction

  // Returns -1 when the coefficient has fewer than t+1 nonzero digits.
  function automatic int csd_pos(input int coef, input int t);
    int n;
    int p;
    n = 0;
    p = -1;
    for (int i = 0; i < 32; i++) begin
      if (csd_digit(coef, i) != 0) begin
        if (n == t && p < 0) p = i;
        n++;
      end
    end
    return p;
  endfunction

  function automatic int max_terms(input int coef_w);
    return (coef_w + 2) / 2;
  endfunction

  function automatic int tree_levels(input int coef_w);
    int l;
    l = clog2(max_terms(coef_w));
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int level_terms(input int n_first, input int k);
    int n;
    n = n_first;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/online_ccm_pipe_level.sv
// Carry-free signed-digit adder and one registered adder-tree level.
// online_adder is combinational: D+D digits in, D+1 digits out, no carry ripple.
module online_adder
  import online_ccm_pipe_pkg::*;
#(
  parameter int D = 12
) (
  input  logic [2*D-1:0] i_a,
  input  logic [2*D-1:0] i_b,
  input  logic           i_cin,
  output logic [2*D+1:0] o_s
);

  logic [D-1:0] w_neg;
  logic [D:0]   w_lneg;
  logic [D:0]   w_tp;
  logic [D:0]   w_tn;
  logic [D-1:0] w_wp;
  logic [D-1:0] w_wn;

  // A position whose lower neighbour holds no negative digit can only receive a
  // transfer of 0/+1, so its interim digit is steered into {-1,0}; otherwise into {0,+1}.
  always_comb begin
    int s;
    int z;
    s      = 0;
    z      = 0;
    w_neg  = '0;
    w_lneg = '0;
    w_tp   = '0;
    w_tn   = '0;
    w_wp   = '0;
    w_wn   = '0;
    o_s    = '0;
    w_tp[0] = i_cin;
    for (int i = 0; i < D; i++) begin
      w_neg[i]    = (i_a[2*i+DIG_N] & ~i_a[2*i+DIG_P]) | (i_b[2*i+DIG_N] & ~i_b[2*i+DIG_P]);
      w_lneg[i+1] = w_neg[i];
    end
    for (int i = 0; i < D; i++) begin
      s = int'(i_a[2*i+DIG_P]) - int'(i_a[2*i+DIG_N]) + int'(i_b[2*i+DIG_P]) - int'(i_b[2*i+DIG_N]);
      if (s == 2) begin
        w_tp[i+1] = 1'b1;
      end else if (s == -2) begin
        w_tn[i+1] = 1'b1;
      end else if (s == 1) begin
        if (!w_lneg[i]) begin
          w_tp[i+1] = 1'b1;
          w_wn[i]   = 1'b1;
        end else begin
          w_wp[i] = 1'b1;
        end
      end else if (s == -1) begin
        if (!w_lneg[i]) begin
          w_wn[i] = 1'b1;
        end else begin
          w_tn[i+1] = 1'b1;
          w_wp[i]   = 1'b1;
        end
      end
    end
    for (int i = 0; i < D; i++) begin
      z = int'(w_wp[i]) - int'(w_wn[i]) + int'(w_tp[i]) - int'(w_tn[i]);
      o_s[2*i+DIG_P] = (z == 1);
      o_s[2*i+DIG_N] = (z == -1);
    end
    o_s[2*D+DIG_P] = w_tp[D];
    o_s[2*D+DIG_N] = w_tn[D];
  end

endmodule

module online_ccm_level
  import online_ccm_pipe_pkg::*;
#(
  parameter  int IN_D  = 12,
  parameter  int N_IN  = 4,
  localparam int N_OUT = (N_IN + 1) / 2,
  localparam int OUT_D = IN_D + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [N_IN*2*IN_D-1:0]   i_terms,
  output logic [N_OUT*2*OUT_D-1:0] o_terms
);

  logic [N_OUT*2*OUT_D-1:0] w_sum;
  logic [N_OUT*2*OUT_D-1:0] r_sum;

  for (genvar p = 0; p < N_IN / 2; p++) begin : g_pair
    online_adder #(.D(IN_D)) u_add (
      .i_a   (i_terms[(2*p)*2*IN_D +: 2*IN_D]),
      .i_b   (i_terms[(2*p+1)*2*IN_D +: 2*IN_D]),
      .i_cin (1'b0),
      .o_s   (w_sum[p*2*OUT_D +: 2*OUT_D])
    );
  end

  if ((N_IN % 2) != 0) begin : g_odd
    assign w_sum[(N_OUT-1)*2*OUT_D +: 2*OUT_D] = {DIG_ZERO, i_terms[(N_IN-1)*2*IN_D +: 2*IN_D]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_sum <= '0;
    else if (ce) r_sum <= w_sum;
  end

  assign o_terms = r_sum;

endmodule

// File: rtl/online_ccm_pipe.sv
// Pipelined online (MSD-first signed-digit) constant multiplier y = COEF*x, latency L+1 enabled cycles.
// Optional macro ONLINE_CCM_NEG_EN adds a per-sample neg input that negates the product.
module online_ccm_pipe
  import online_ccm_pipe_pkg::*;
#(
  parameter  int STAGE  = 4,
  parameter  int COEF   = 117,
  parameter  int COEF_W = 7,
  localparam int MAX_T  = max_terms(COEF_W),
  localparam int L      = tree_levels(COEF_W),
  localparam int TW     = STAGE + COEF_W + 1,
  localparam int OUT_D  = TW + L,
  localparam int LAT    = L + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               valid_in,
  input  logic [2*STAGE-1:0] x,
`ifdef ONLINE_CCM_NEG_EN
  input  logic               neg,
`endif
  output logic               valid_out,
  output logic [2*OUT_D-1:0] y
);

  logic [2*STAGE-1:0]   r_x;
  logic [LAT-1:0]       r_valid;
  logic [MAX_T*2*TW-1:0] w_terms;
  logic [2*OUT_D-1:0]   w_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_valid <= '0;
    end else if (ce) begin
      r_x     <= x;
      r_valid <= {r_valid[LAT-2:0], valid_in};
    end
  end

  // One shifted copy of x per nonzero CSD digit; a -1 digit negates by bitwise inversion.
  for (genvar t = 0; t < MAX_T; t++) begin : g_term
    localparam int POS = csd_pos(COEF, t);
    if (POS >= 0) begin : g_used
      localparam int SGN = csd_digit(COEF, POS);
      logic [2*TW-1:0] w_shift;
      assign w_shift = {{(2*(TW-STAGE)){1'b0}}, r_x} << (2*POS);
      assign w_terms[t*2*TW +: 2*TW] = (SGN < 0) ? ~w_shift : w_shift;
    end else begin : g_unused
      assign w_terms[t*2*TW +: 2*TW] = '0;
    end
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int IN_D  = TW + k - 1;
    localparam int N_IN  = level_terms(MAX_T, k - 1);
    localparam int N_OUT = level_terms(MAX_T, k);
    logic [N_OUT*2*(IN_D+1)-1:0] w_out;
    if (k == 1) begin : g_first
      online_ccm_level #(.IN_D(IN_D), .N_IN(N_IN)) u_lvl (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .i_terms (w_terms),
        .o_terms (w_out)
      );
    end else begin : g_next
      online_ccm_level #(.IN_D(IN_D), .N_IN(N_IN)) u_lvl (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .i_terms (g_lvl[k-1].w_out),
        .o_terms (w_out)
      );
    end
  end

  assign w_prod    = g_lvl[L].w_out;
  assign valid_out = r_valid[LAT-1];

`ifdef ONLINE_CCM_NEG_EN
  logic [LAT-1:0] r_neg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_neg <= '0;
    else if (ce) r_neg <= {r_neg[LAT-2:0], neg};
  end

  assign y = r_neg[LAT-1] ? ~w_prod : w_prod;
`else
  assign y = w_prod;
`endif

endmodule

// File: tb/tb_online_ccm_pipe.sv
// Scoreboard bench for online_ccm_pipe: COEF=117 main instance plus a COEF sweep bank.
module tb_online_ccm_pipe;

  localparam int LAT   = 3;
  localparam int OUT_D = 14;
  localparam int COEF  = 117;
  localparam int SW_COEF [4] = '{1, 3, 85, 127};
`ifdef ONLINE_CCM_NEG_EN
  localparam bit NEG_ON = 1'b1;
`else
  localparam bit NEG_ON = 1'b0;
`endif

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst, ce, valid_in, neg;
  logic [7:0] x;
  logic valid_out;
  logic [2*OUT_D-1:0] y;
  logic v_sw [4];
  logic [2*OUT_D-1:0] y_sw [4];

  int     n_pass = 0;
  int     n_total = 0;
  int     ecnt = 0;
  bit     sweep_on = 1'b0;
  logic   exp_v = 1'b0;
  longint exp_y = 0;
  exp_t   q_main [$];
  longint q_sw [4][$];

  always #5 clk = ~clk;

  online_ccm_pipe #(.STAGE(4), .COEF(COEF), .COEF_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .valid_in  (valid_in),
    .x         (x),
`ifdef ONLINE_CCM_NEG_EN
    .neg       (neg),
`endif
    .valid_out (valid_out),
    .y         (y)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    online_ccm_pipe #(.STAGE(4), .COEF(SW_COEF[g]), .COEF_W(7)) dut_sw (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .valid_in  (valid_in),
      .x         (x),
`ifdef ONLINE_CCM_NEG_EN
      .neg       (1'b0),
`endif
      .valid_out (v_sw[g]),
      .y         (y_sw[g])
    );
  end

  function automatic longint dec(input logic [2*OUT_D-1:0] v);
    longint s;
    s = 0;
    for (int j = 0; j < OUT_D; j++)
      s += (longint'(v[2*j+1]) - longint'(v[2*j])) * (longint'(1) << j);
    return s;
  endfunction

  // Drive one cycle and advance the reference model by one edge.
  task automatic tick(input logic v, input logic [7:0] xx, input logic c, input logic ng);
    exp_t   e;
    longint xv;
    valid_in = v;
    x        = xx;
    ce       = c;
    neg      = ng;
    xv = dec({20'b0, xx});
    @(posedge clk);
    if (c) begin
      ecnt++;
      if (v) begin
        e.due = ecnt + LAT - 1;
        e.val = (NEG_ON && ng) ? -(COEF * xv) : COEF * xv;
        q_main.push_back(e);
        if (sweep_on)
          for (int g = 0; g < 4; g++) q_sw[g].push_back(SW_COEF[g] * xv);
      end
      if (q_main.size() > 0 && q_main[0].due == ecnt) begin
        e = q_main.pop_front();
        exp_v = 1'b1;
        exp_y = e.val;
      end else begin
        exp_v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ce = 1'b0; valid_in = 1'b0; x = '0; neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (valid_out !== 1'b0 || y !== '0) $display("FAIL reset: valid_out=%b y=%h, want 0/0", valid_out, y);
    else n_pass++;
    n_total++;
    if (v_sw[0] !== 1'b0 || v_sw[3] !== 1'b0) $display("FAIL reset_sweep: valid_out=%b/%b, want 0", v_sw[0], v_sw[3]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b1;
  endtask

  task automatic test_single;
    for (int i = 0; i < 6; i++) begin
      tick(i == 0, (i == 0) ? 8'h02 : 8'h00, 1'b1, 1'b0);
      n_total++;
      if (valid_out !== exp_v || (exp_v && dec(y) !== exp_y))
        $display("FAIL single cyc%0d: valid_out=%b y=%0d, want valid_out=%b y=%0d", i, valid_out, dec(y), exp_v, exp_y);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [3] = '{8'hAA, 8'h55, 8'hFF};
    for (int i = 0; i < 7; i++) begin
      tick(i < 3, (i < 3) ? seq[i] : 8'h00, 1'b1, 1'b0);
      n_total++;
      if (valid_out !== exp_v || (exp_v && dec(y) !== exp_y))
        $display("FAIL b2b cyc%0d: valid_out=%b y=%0d, want valid_out=%b y=%0d", i, valid_out, dec(y), exp_v, exp_y);
      else n_pass++;
    end
  endtask

  task automatic test_ce_stall;
    logic [7:0] seq [9] = '{8'hAA, 8'h55, 8'hFF, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       vin [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic       cen [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      tick(vin[i], seq[i], cen[i], 1'b0);
      n_total++;
      if (valid_out !== exp_v || (exp_v && dec(y) !== exp_y))
        $display("FAIL ce_stall cyc%0d: valid_out=%b y=%0d, want valid_out=%b y=%0d", i, valid_out, dec(y), exp_v, exp_y);
      else n_pass++;
    end
  endtask

  task automatic test_rst_flush;
    logic [7:0] seq [3] = '{8'hAA, 8'h55, 8'hFF};
    for (int i = 0; i < 3; i++) tick(1'b1, seq[i], 1'b1, 1'b0);
    n_total++;
    if (valid_out !== exp_v || dec(y) !== exp_y)
      $display("FAIL rst_pre: valid_out=%b y=%0d, want valid_out=%b y=%0d", valid_out, dec(y), exp_v, exp_y);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (valid_out !== 1'b0 || y !== '0) $display("FAIL rst_async: valid_out=%b y=%h, want 0/0", valid_out, y);
    else n_pass++;
    q_main.delete();
    exp_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      n_total++;
      if (valid_out !== 1'b0) $display("FAIL rst_stale cyc%0d: valid_out=%b, want 0", i, valid_out);
      else n_pass++;
    end
  endtask

  task automatic test_sweep;
    logic [7:0] xx;
    longint     sv;
    int         r;
    sweep_on = 1'b1;
    for (int n = 0; n < 85; n++) begin
      xx = '0;
      r  = n;
      for (int i = 0; i < 4; i++) begin
        if (r % 3 == 1) xx[2*i+1] = 1'b1;
        if (r % 3 == 2) xx[2*i]   = 1'b1;
        r = r / 3;
      end
      tick(n < 81, xx, 1'b1, 1'b0);
      for (int g = 0; g < 4; g++) begin
        if (v_sw[g]) begin
          n_total++;
          if (q_sw[g].size() == 0) begin
            $display("FAIL sweep_extra coef=%0d: valid_out=1 y=%0d, want no output", SW_COEF[g], dec(y_sw[g]));
          end else begin
            sv = q_sw[g].pop_front();
            if (dec(y_sw[g]) !== sv)
              $display("FAIL sweep coef=%0d n=%0d: y=%0d, want %0d", SW_COEF[g], n, dec(y_sw[g]), sv);
            else n_pass++;
          end
        end
      end
      n_total++;
      if (valid_out !== exp_v || (exp_v && dec(y) !== exp_y))
        $display("FAIL sweep_main n=%0d: valid_out=%b y=%0d, want valid_out=%b y=%0d", n, valid_out, dec(y), exp_v, exp_y);
      else n_pass++;
    end
    for (int g = 0; g < 4; g++) begin
      n_total++;
      if (q_sw[g].size() != 0) $display("FAIL sweep_missing coef=%0d: %0d outputs missing, want 0", SW_COEF[g], q_sw[g].size());
      else n_pass++;
    end
    sweep_on = 1'b0;
  endtask

`ifdef ONLINE_CCM_NEG_EN
  task automatic test_neg;
    for (int i = 0; i < 6; i++) begin
      tick(i < 2, (i < 2) ? 8'h02 : 8'h00, 1'b1, i == 0);
      n_total++;
      if (valid_out !== exp_v || (exp_v && dec(y) !== exp_y))
        $display("FAIL neg cyc%0d: valid_out=%b y=%0d, want valid_out=%b y=%0d", i, valid_out, dec(y), exp_v, exp_y);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ce_stall();
    test_rst_flush();
    test_sweep();
`ifdef ONLINE_CCM_NEG_EN
    test_neg();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
